// File: rtl/fetch_queue.sv
// Instruction fetch queue. It keeps a fetch PC, issues sequential word fetches,
// and buffers the returned {pc, instr} pairs in a first-word-fall-through
// circular buffer for the IF/ID stage. A redirect flushes the queue and
// reloads the fetch PC. Reset does the same, but loads RESET_PC instead.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [4:0]  level
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]      LVL_FULL = 5'(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

    logic [31:0]   r_fetch_pc;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [4:0]    r_level;
    logic [31:0]   r_buf_pc    [DEPTH];
    logic [31:0]   r_buf_instr [DEPTH];

    logic w_push;
    logic w_pop;

    // A request depends only on free space. A pop in the same cycle does not
    // count, so a full queue never requests, even while it drains.
    always_comb begin
        imem_req  = !rst && !redirect && (r_level < LVL_FULL);
        imem_addr = r_fetch_pc;
        id_valid  = (r_level != 5'd0);
        id_instr  = r_buf_instr[r_rptr];
        id_pc     = r_buf_pc[r_rptr];
        level     = r_level;
        // A redirect or reset cycle discards any concurrent ack and pop.
        w_push    = imem_req && imem_ack;
        w_pop     = id_valid && id_ready && !rst && !redirect;
    end

    // Control state: the fetch PC, the pointers and the occupancy. A flush
    // only moves the read pointer onto the write pointer; storage is left as is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= 5'd0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_rptr     <= r_wptr;
            r_level    <= 5'd0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd1;
                r_wptr     <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 5'd1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 5'd1;
            end
        end
    end

    // Buffer storage is written on every accepted fetch and is never cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wptr]    <= r_fetch_pc;
            r_buf_instr[r_wptr] <= imem_data;
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'd0, sets the fetch PC loaded at reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 redirect  input  1  taken branch/jump from the MEM stage; flush and refetch.
REQ-006 redirect_pc  input  32  new fetch address, valid when redirect=1.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  word address of the request (current fetch PC).
REQ-009 imem_ack  input  1  memory accepts the request; imem_data is valid in this same cycle.
REQ-010 imem_data  input  32  fetched instruction word.
REQ-011 id_valid  output  1  head entry presented to the IF/ID buffer.
REQ-012 id_ready  input  1  IF/ID buffer accepts the head entry (0 = decode stall).
REQ-013 id_instr  output  32  head-entry instruction.
REQ-014 id_pc  output  32  head-entry PC.
REQ-015 level  output  5  current occupancy, 0..DEPTH.

Function
REQ-016 The block SHALL hold a 32-bit fetch_pc register, a DEPTH-entry circular buffer of {pc, instr}, read/write pointers, and an occupancy counter.
REQ-017 imem_req SHALL be 1 iff rst=0, redirect=0 and level<DEPTH; a pop in the same cycle does not enable a request.
REQ-018 imem_addr SHALL equal fetch_pc at all times.
REQ-019 A fetch SHALL complete when imem_req=1 and imem_ack=1: push {fetch_pc, imem_data} and set fetch_pc to fetch_pc+1.
REQ-020 imem_ack while imem_req=0 SHALL be ignored.
REQ-021 fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFFFFFF -> 32'h00000000).
REQ-022 The queue SHALL be first-word-fall-through: id_valid=(level!=0), and id_instr/id_pc SHALL show the head entry.
REQ-023 Latency from the ack cycle to visibility on id_* with an empty queue SHALL be exactly 1 cycle.
REQ-024 A pop SHALL occur when id_valid=1 and id_ready=1, advancing the read pointer.
REQ-025 While id_valid=1 and id_ready=0, id_instr and id_pc SHALL hold stable.
REQ-026 A push and pop in the same cycle SHALL leave level unchanged and preserve order.
REQ-027 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.
REQ-028 When redirect=1 and rst=0, the next state SHALL be: level=0, pointers equal, fetch_pc=redirect_pc.
REQ-029 During a redirect cycle, any imem_ack or pop SHALL be discarded (no push, no pop effect).
REQ-030 id_valid SHALL be 0 in the cycle following a redirect.
REQ-031 Back-to-back redirects SHALL each reload fetch_pc; the last one wins.
REQ-032 Order is FIFO strictly: entries leave in the PC order they were fetched.

Reset
REQ-033 With rst=1 at a clock edge: fetch_pc=RESET_PC, level=0, pointers=0, regardless of redirect, ack or id_ready.
REQ-034 In a cycle where rst=1, imem_req SHALL be 0; id_valid SHALL be 0 from the cycle after reset is sampled.
REQ-035 Buffer storage need not be cleared; id_instr/id_pc SHALL be treated as don't-care while id_valid=0.
REQ-036 Reset asserted mid-operation SHALL discard all queued entries and any concurrent ack.
REQ-037 In the first cycle after rst deasserts, imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-038 Reset, then imem_ack=1 every cycle, id_ready=1, imem_data=0x1000+addr -> imem_addr 0,1,2,...; id_pc=0/id_instr=0x1000 one cycle after the first ack; level stays 1.
REQ-039 id_ready=0, imem_ack=1 continuous -> after 4 acks level=4, imem_req=0, id_pc held at 0; no fifth push.
REQ-040 Full queue, id_ready=1 for one cycle -> imem_req stays 0 that cycle; next cycle level=3, imem_req=1, imem_addr=4, id_pc=1.
REQ-041 level=3 with imem_ack=1, redirect=1, redirect_pc=0x40 in the same cycle -> next cycle level=0, id_valid=0, imem_addr=0x40; acked word never appears on id_*.
REQ-042 RESET_PC=32'hFFFFFFFF, ack continuous -> imem_addr 0xFFFFFFFF then 0x00000000; id_pc sequence matches.
REQ-043 rst=1 for one cycle at level=2 with redirect=1 -> next cycle level=0, id_valid=0; first post-reset request at RESET_PC, not redirect_pc.
